// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbiter sharing a DEPTH x WIDTH flip-flop
// register bank between two requesters (A and B).
// Each requester issues single-word reads or writes. An IDLE state picks a
// winner, and a one-cycle XFER state performs the access.
module reg_bank_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic             WrA,
  input  logic             WrB,
  input  logic [AW-1:0]    AddrA,
  input  logic [AW-1:0]    AddrB,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             GntA,
  output logic             GntB,
  output logic [WIDTH-1:0] RdData,
  output logic             RdValid,
  output logic             RdOwner,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE,
    XFER_A,
    XFER_B
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;        // requester served last: 0 = A, 1 = B
  logic             pick_b;
  logic             cmd_wr_q, cmd_wr_d;
  logic [AW-1:0]    cmd_addr_q, cmd_addr_d;
  logic [WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_owner_q, rd_owner_d;

  // Arbitration and sequencing: pick a winner in IDLE, latch its command,
  // and always return to IDLE after one XFER cycle.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    // B wins if it is the only requester, or on contention when A went last.
    pick_b     = ReqB && (!ReqA || !last_q);
    case (state_q)
      IDLE: begin
        if (pick_b) begin
          state_d    = XFER_B;
          last_d     = 1'b1;
          cmd_wr_d   = WrB;
          cmd_addr_d = AddrB;
          cmd_data_d = DataB;
        end else if (ReqA) begin
          state_d    = XFER_A;
          last_d     = 1'b0;
          cmd_wr_d   = WrA;
          cmd_addr_d = AddrA;
          cmd_data_d = DataA;
        end
      end
      XFER_A, XFER_B: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Bank access at the edge that ends an XFER cycle; read results are held until the next read.
  always_comb begin
    bank_d     = bank_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_owner_d = rd_owner_q;
    if (state_q != IDLE) begin
      if (cmd_wr_q) begin
        bank_d[cmd_addr_q] = cmd_data_q;
      end else begin
        rd_data_d  = bank_q[cmd_addr_q];
        rd_valid_d = 1'b1;
        rd_owner_d = (state_q == XFER_B);
      end
    end
  end

  // State, command and bank registers, cleared asynchronously.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      cmd_wr_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      bank_q     <= '{default: '0};
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      bank_q     <= bank_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Grants are decoded from the state register, so they are registered and
  // drop as soon as reset forces IDLE.
  assign GntA    = (state_q == XFER_A);
  assign GntB    = (state_q == XFER_B);
  assign Busy    = (state_q != IDLE);
  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;
  assign RdOwner = rd_owner_q;

endmodule
